led_scan_driver: RTL and testbench
==================================

// Module: led_scan_driver
// PURPOSE
// - Reads 24-bit RGB pixels from frame_ram (read-only client) and drives the HUB75 panel pins.
// - Uses binary-coded modulation (BCM) with BITS bit-planes per row; two rows are shifted at once (top/bottom half).
// - Sits between frame_ram port A and the panel pins in led_display. Whatever fills the RAM writes it elsewhere.
// PARAMETERS
// - COLS        64   panel width in pixels; the column counter wraps at COLS-1.
// - ROWS        32   panel height; scan rows = ROWS/2; ADDR_W = $clog2(ROWS/2).
// - BITS        8    bit-planes per colour, 1..8; plane b uses pixel bits R[16+b], G[8+b], B[b].
// - BASE_TICKS  4    display clocks for plane 0; plane b is shown for BASE_TICKS<<b clocks.
// PORTS
// - clk_in          in   1       system clock, 100 MHz
// - n_reset_in      in   1       synchronous, active-low reset
// - ram_en_out      out  1       RAM read enable
// - ram_we_out      out  1       RAM write enable; tied 0
// - ram_addr_out    out  16      pixel address = row*COLS + col
// - ram_data_in     in   24      pixel {R[23:16],G[15:8],B[7:0]}; valid 1 clk after address
// - rgb_top_out     out  3       {R1,G1,B1}
// - rgb_bot_out     out  3       {R2,G2,B2}
// - bclk_out        out  1       shift clock; panel samples on the rising edge
// - lat_out         out  1       latch pulse, active high
// - oe_n_out        out  1       output enable, active low (1 = blanked)
// - row_addr_out    out  ADDR_W  {..,C,B,A}
// - frame_start_out out  1       1-clk pulse at the latch of row 0, plane 0
// BEHAVIOUR
// - Reset values: ram_en=0, ram_addr=0, rgb=0, bclk=0, lat=0, oe_n=1, row_addr=0, frame_start=0.
// - Reset: sync; asserting it mid-operation aborts any shift or display and returns to SHIFT of row 0, plane 0, col 0 next clk.
// - Column slot is 4 clks; ram_addr_out and ram_en_out are valid during the cycle they are named for:
//   - C0: ram_addr = top pixel (row r), ram_en=1.
//   - C1: ram_addr = bottom pixel (row r+ROWS/2), ram_en=1; top data captured at the end of C1.
//   - C2: bottom data captured; rgb outputs update at the end of C2; bclk=0.
//   - C3: bclk=1; data held stable through C3 and C0 of the next slot.
//   - ram_en=0 outside C0/C1.
// - Plane shift takes COLS*4 clks and runs concurrently with the display of the previous plane.
// - FSM states: SHIFT -> WAIT -> BLANK -> LATCH -> SHIFT.
//   - WAIT: holds until the display timer is 0. Passes through in 1 clk if the timer is already 0.
//   - BLANK: 1 clk with oe_n=1.
//   - LATCH: 1 clk with lat=1, oe_n=1; row_addr_out takes the row just shifted.
//   - Next clk: oe_n=0, timer loaded with BASE_TICKS<<b, and the next plane's SHIFT begins.
// - Display timer decrements once per clk while nonzero. oe_n stays 0 until the timer reaches 0, then goes 1 (stays blanked until the next latch).
// - Scan order: plane 0..BITS-1 for row r, then row r+1. After plane BITS-1 of row ROWS/2-1, wrap to row 0, plane 0.
// - frame_start_out pulses in the LATCH cycle for row 0, plane 0.
// - First frame after reset: oe_n=1 until the first LATCH. WAIT is immediate (timer=0).
// - Address arithmetic is 16-bit, unsigned, no overflow for COLS*ROWS <= 65536.
// CONFIGURATION
// - TEST_PATTERN_EN defined:
//   - Adds port pattern_sel_in (in, 1).
//   - When 1, ram_data_in is ignored and the pixel = {3{col*4}} (8-bit gray ramp by column, col 63 -> 0xFC).
//   - RAM accesses are still issued identically.
//   - pattern_sel_in is sampled at each column slot C0.
// - TEST_PATTERN_EN undefined: no port; pixels always come from ram_data_in.
// TESTING
// - Reset release, RAM all 0: ram_addr sequence 0,32*64/2=1024,1,1025,... at C0/C1.
//   - 64 bclk rising edges, then lat=1 for 1 clk with row_addr=0, then oe_n=0.
// - RAM[0]=0xFF0000, RAM[1024]=0x0000FF: on the first bclk rise of plane 0, rgb_top=3'b100 and rgb_bot=3'b001.
// - Pixel 0x800000 at row 0 col 0: R1 is 1 only during the plane 7 shift; oe_n low for 512 clks after that latch (BASE_TICKS=4).
// - Count clks from latch to latch:
//   - Plane 0 -> plane 1: 256 shift + 1 WAIT + 1 BLANK + 1 LATCH = 259 clks (timer 4 already expired).
//   - Plane 7 -> next row's plane 0: oe_n low for 512 clks.
// - Run a full frame: frame_start_out pulses once per 16 rows * 8 planes; row_addr wraps from 15 to 0.
// - Assert n_reset_in mid-shift (col 30, row 5):
//   - Next clk all outputs hold reset values.
//   - After release, the ram_addr sequence restarts at 0.
// - TEST_PATTERN_EN with pattern_sel_in=1 and plane 7: rgb_top=3'b111 for cols 32..63 and 3'b000 for cols 0..31.

Source files
------------

// File: rtl/led_scan_driver.sv
// led_scan_driver: HUB75 binary-coded-modulation scan driver fed from a 24-bit frame RAM (read-only client).
// Latency: a column's rgb appears 3 clks after its top-pixel address; one plane shifts in COLS*4 clks.
// Backpressure: none; RAM data must arrive 1 clk after the address. Optional gray-ramp test pattern: TEST_PATTERN_EN.
module led_scan_driver #(
  parameter int COLS       = 64,
  parameter int ROWS       = 32,
  parameter int BITS       = 8,
  parameter int BASE_TICKS = 4,
  localparam int ADDR_W    = $clog2(ROWS/2)
) (
  input  logic              clk_in,
  input  logic              n_reset_in,
`ifdef TEST_PATTERN_EN
  input  logic              pattern_sel_in,
`endif
  output logic              ram_en_out,
  output logic              ram_we_out,
  output logic [15:0]       ram_addr_out,
  input  logic [23:0]       ram_data_in,
  output logic [2:0]        rgb_top_out,
  output logic [2:0]        rgb_bot_out,
  output logic              bclk_out,
  output logic              lat_out,
  output logic              oe_n_out,
  output logic [ADDR_W-1:0] row_addr_out,
  output logic              frame_start_out
);

  localparam int HALF  = ROWS / 2;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PL_W  = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int TMR_W = $clog2((BASE_TICKS << (BITS - 1)) + 1);

  typedef enum logic [1:0] {ST_SHIFT, ST_WAIT, ST_BLANK, ST_LATCH} state_t;

  state_t             state;
  state_t             next_state;
  logic               run;        // low for the cycle after reset so outputs show reset values
  logic [1:0]         phase;      // C0..C3 within a column slot
  logic [COL_W-1:0]   col;
  logic [ADDR_W-1:0]  row;
  logic [PL_W-1:0]    plane;
  logic [TMR_W-1:0]   timer;
  logic [2:0]         top_bits;
  logic [23:0]        pixel;
  logic               last_col;
  logic [15:0]        top_addr;
  logic [15:0]        bot_addr;

  // Select bits R[16+b], G[8+b], B[b] of a pixel for plane b.
  function automatic logic [2:0] plane_rgb(input logic [23:0] p, input logic [PL_W-1:0] b);
    logic [23:0] s;
    s = p >> b;
    return {s[16], s[8], s[0]};
  endfunction

  assign last_col = (col == COL_W'(COLS - 1));
  assign top_addr = 16'(row) * 16'(COLS) + 16'(col);
  assign bot_addr = (16'(row) + 16'(HALF)) * 16'(COLS) + 16'(col);

`ifdef TEST_PATTERN_EN
  logic       pat_sel;
  logic [7:0] gray;

  // Latch the pattern select once per column slot so a slot never mixes sources.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in)
      pat_sel <= 1'b0;
    else if (run && state == ST_SHIFT && phase == 2'd0)
      pat_sel <= pattern_sel_in;
  end

  // Gray ramp by column, or the RAM word; RAM reads are issued either way.
  always_comb begin
    gray  = 8'({col, 2'b00});
    pixel = pat_sel ? {gray, gray, gray} : ram_data_in;
  end
`else
  // Pixels always come straight from the RAM read port.
  always_comb begin
    pixel = ram_data_in;
  end
`endif

  // State register.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in)
      state <= ST_SHIFT;
    else
      state <= next_state;
  end

  // Next state: shift a full plane, wait out the previous plane's display, blank, latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_SHIFT: if (run && phase == 2'd3 && last_col) next_state = ST_WAIT;
      ST_WAIT:  if (timer == '0) next_state = ST_BLANK;
      ST_BLANK: next_state = ST_LATCH;
      ST_LATCH: next_state = ST_SHIFT;
      default:  next_state = ST_SHIFT;
    endcase
  end

  // Outputs decoded from state and slot phase; RAM address only driven in C0/C1.
  always_comb begin
    ram_en_out      = 1'b0;
    ram_addr_out    = '0;
    bclk_out        = 1'b0;
    lat_out         = (state == ST_LATCH);
    frame_start_out = (state == ST_LATCH) && (row == '0) && (plane == '0);
    if (run && state == ST_SHIFT) begin
      ram_en_out = (phase == 2'd0) || (phase == 2'd1);
      bclk_out   = (phase == 2'd3);
      if (phase == 2'd0)
        ram_addr_out = top_addr;
      else if (phase == 2'd1)
        ram_addr_out = bot_addr;
    end
  end

  assign ram_we_out = 1'b0;
  // The panel is lit exactly while the display timer counts down.
  assign oe_n_out   = (timer == '0);

  // Column slot sequencing; counters sit at C0/col 0 whenever not shifting.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      run   <= 1'b0;
      phase <= 2'd0;
      col   <= '0;
    end else begin
      run <= 1'b1;
      if (run && state == ST_SHIFT) begin
        phase <= phase + 2'd1;
        if (phase == 2'd3)
          col <= last_col ? '0 : col + COL_W'(1);
      end
    end
  end

  // Advance plane, then row, after each latch; wrap to row 0 plane 0 at frame end.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      row   <= '0;
      plane <= '0;
    end else if (state == ST_LATCH) begin
      if (plane == PL_W'(BITS - 1)) begin
        plane <= '0;
        row   <= (row == ADDR_W'(HALF - 1)) ? '0 : row + ADDR_W'(1);
      end else begin
        plane <= plane + PL_W'(1);
      end
    end
  end

  // Display timer: loaded with the latched plane's weight, counts down to 0.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in)
      timer <= '0;
    else if (state == ST_LATCH)
      timer <= TMR_W'(BASE_TICKS) << plane;
    else if (timer != '0)
      timer <= timer - TMR_W'(1);
  end

  // Row address follows the row being latched, changing as LATCH begins.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in)
      row_addr_out <= '0;
    else if (state == ST_BLANK)
      row_addr_out <= row;
  end

  // Capture top data at end of C1, present both halves at end of C2.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      top_bits    <= 3'b000;
      rgb_top_out <= 3'b000;
      rgb_bot_out <= 3'b000;
    end else if (run && state == ST_SHIFT) begin
      if (phase == 2'd1)
        top_bits <= plane_rgb(pixel, plane);
      if (phase == 2'd2) begin
        rgb_top_out <= top_bits;
        rgb_bot_out <= plane_rgb(pixel, plane);
      end
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Testbench for led_scan_driver: timeline reference model of the scan schedule plus RAM model.
// Expected outputs derive from latch times, plane weights and pixel bits, not from the RTL state machine.
// Scenarios: reset, first plane, MSB plane, full frame, mid-shift reset, optional test pattern.
`timescale 1ns/1ps
module tb_led_scan_driver;
  localparam int COLS = 64, ROWS = 32, BITS = 8, BASE = 4;
  localparam int HALF = ROWS / 2;
  localparam int AW   = $clog2(HALF);

  logic          clk_in = 1'b0;
  logic          n_reset_in = 1'b0;
  logic          ram_en_out, ram_we_out;
  logic [15:0]   ram_addr_out;
  logic [23:0]   ram_data_in = '0;
  logic [2:0]    rgb_top_out, rgb_bot_out;
  logic          bclk_out, lat_out, oe_n_out, frame_start_out;
  logic [AW-1:0] row_addr_out;
`ifdef TEST_PATTERN_EN
  logic          pattern_sel_in = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] mem [0:COLS*ROWS-1];

  // model state
  int t, m_row, m_plane, m_lprev, m_tprev, m_latrow, m_nlat;
  bit m_pat = 1'b0;
  // expected values for the current cycle
  logic        e_en, e_bclk, e_lat, e_oe_n, e_fs, e_shift;
  logic [15:0] e_addr;
  logic [2:0]  e_top, e_bot;
  int          e_row_addr, e_col, e_ph;

  always #5 clk_in = ~clk_in;

  led_scan_driver #(.COLS(COLS), .ROWS(ROWS), .BITS(BITS), .BASE_TICKS(BASE)) dut (
    .clk_in(clk_in),
    .n_reset_in(n_reset_in),
`ifdef TEST_PATTERN_EN
    .pattern_sel_in(pattern_sel_in),
`endif
    .ram_en_out(ram_en_out),
    .ram_we_out(ram_we_out),
    .ram_addr_out(ram_addr_out),
    .ram_data_in(ram_data_in),
    .rgb_top_out(rgb_top_out),
    .rgb_bot_out(rgb_bot_out),
    .bclk_out(bclk_out),
    .lat_out(lat_out),
    .oe_n_out(oe_n_out),
    .row_addr_out(row_addr_out),
    .frame_start_out(frame_start_out)
  );

  // Synchronous RAM: data for an address presented in one cycle appears in the next.
  initial begin : ram_model
    logic [15:0] a;
    logic        en;
    forever begin
      @(negedge clk_in);
      a  = ram_addr_out;
      en = ram_en_out;
      @(posedge clk_in);
      #1;
      if (en) ram_data_in = mem[a];
    end
  end

  function automatic logic [2:0] bits_of(input logic [23:0] p, input int b);
    return {p[16+b], p[8+b], p[b]};
  endfunction

  function automatic logic [23:0] pix_at(input int r, input int c);
    logic [7:0] g;
    g = 8'(c * 4);
    if (m_pat) return {g, g, g};
    return mem[r*COLS + c];
  endfunction

  task automatic model_init();
    t = 0; m_row = 0; m_plane = 0; m_lprev = -1; m_tprev = 0; m_latrow = 0; m_nlat = 0;
  endtask

  // Each period: shift COLS*4 clks starting the clk after a latch; the next latch comes
  // 3 clks after the later of shift end and display-time end.
  task automatic model_cycle();
    int s, o, lat_t;
    s       = m_lprev + 1;
    o       = t - s;
    e_shift = (o >= 0) && (o < 4*COLS);
    e_col   = o / 4;
    e_ph    = o % 4;
    lat_t   = m_lprev + 3 + ((m_tprev > 4*COLS) ? m_tprev : 4*COLS);
    e_lat   = (t == lat_t);
    e_en    = e_shift && (e_ph < 2);
    e_bclk  = e_shift && (e_ph == 3);
    e_addr  = 16'((((e_ph == 0) ? m_row : m_row + HALF) * COLS) + e_col);
    e_top   = 3'b000;
    e_bot   = 3'b000;
    if (e_shift) begin
      e_top = bits_of(pix_at(m_row, e_col), m_plane);
      e_bot = bits_of(pix_at(m_row + HALF, e_col), m_plane);
    end
    e_oe_n     = !((t > m_lprev) && (t <= m_lprev + m_tprev));
    e_row_addr = e_lat ? m_row : m_latrow;
    e_fs       = e_lat && (m_row == 0) && (m_plane == 0);
    if (e_lat) begin
      m_latrow = m_row;
      m_lprev  = t;
      m_tprev  = BASE << m_plane;
      m_nlat++;
      if (m_plane == BITS - 1) begin
        m_plane = 0;
        m_row   = (m_row + 1) % HALF;
      end else begin
        m_plane++;
      end
    end
    t++;
  endtask

  function automatic bit cycle_matches();
    bit ok;
    ok = 1'b1;
    if (ram_en_out !== e_en || bclk_out !== e_bclk || lat_out !== e_lat || oe_n_out !== e_oe_n ||
        frame_start_out !== e_fs || ram_we_out !== 1'b0 || row_addr_out !== AW'(e_row_addr)) ok = 1'b0;
    if (e_en && ram_addr_out !== e_addr) ok = 1'b0;
    if (e_bclk && (rgb_top_out !== e_top || rgb_bot_out !== e_bot)) ok = 1'b0;
    return ok;
  endfunction

  task automatic report_cycle(input string name);
    $display("FAIL %s t=%0d got en=%b addr=%0d bclk=%b top=%b bot=%b lat=%b oe_n=%b row=%0d fs=%b we=%b | want en=%b addr=%0d bclk=%b top=%b bot=%b lat=%b oe_n=%b row=%0d fs=%b",
             name, t-1, ram_en_out, ram_addr_out, bclk_out, rgb_top_out, rgb_bot_out, lat_out, oe_n_out,
             row_addr_out, frame_start_out, ram_we_out, e_en, e_addr, e_bclk, e_top, e_bot, e_lat, e_oe_n,
             e_row_addr, e_fs);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk_in);
    n_reset_in = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  // Called at a negedge; the next posedge is the release edge and the following cycle is t=0.
  task automatic release_reset();
    n_reset_in = 1'b1;
    model_init();
  endtask

  function automatic logic [31:0] out_vec();
    return {ram_en_out, ram_we_out, ram_addr_out, rgb_top_out, rgb_bot_out, bclk_out, lat_out,
            oe_n_out, row_addr_out, frame_start_out};
  endfunction

  task automatic test_reset();
    logic [31:0] want;
    want = {1'b0, 1'b0, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0};
    apply_reset(3);
    n_cmp++;
    if (out_vec() !== want) begin
      n_bad++;
      $display("FAIL reset_values got %h want %h", out_vec(), want);
    end
  endtask

  task automatic test_first_plane();
    int lt[$];
    int errs, olow, cyc;
    bit seen;
    logic [2:0] ft, fb;
    int l0, l1;
    errs = 0; olow = 0; cyc = 0; seen = 0; ft = 'x; fb = 'x;
    for (int i = 0; i < COLS*ROWS; i++) mem[i] = 24'h0;
    mem[0] = 24'hFF0000;
    mem[HALF*COLS] = 24'h0000FF;
    apply_reset(2);
    release_reset();
    for (int i = 0; i < 3000 && m_nlat < 9 && errs < 10; i++) begin
      @(negedge clk_in);
      model_cycle();
      n_cmp++;
      if (!cycle_matches()) begin n_bad++; errs++; report_cycle("first_plane_cycle"); end
      if (bclk_out === 1'b1 && !seen) begin seen = 1; ft = rgb_top_out; fb = rgb_bot_out; end
      if (lat_out === 1'b1) lt.push_back(cyc);
      if (lt.size() == 8 && oe_n_out === 1'b0) olow++;
      cyc++;
    end
    n_cmp++;
    if (m_nlat < 9) begin n_bad++; $display("FAIL first_plane_timeout latches=%0d want 9", m_nlat); end
    n_cmp++;
    if (ft !== 3'b100) begin n_bad++; $display("FAIL first_bclk_top got %b want 100", ft); end
    n_cmp++;
    if (fb !== 3'b001) begin n_bad++; $display("FAIL first_bclk_bot got %b want 001", fb); end
    l0 = (lt.size() > 0) ? lt[0] : -1;
    l1 = (lt.size() > 1) ? lt[1] : -1;
    n_cmp++;
    if (l0 != 4*COLS + 2) begin n_bad++; $display("FAIL first_latch_cycle got %0d want %0d", l0, 4*COLS + 2); end
    n_cmp++;
    if (l1 - l0 != 259) begin n_bad++; $display("FAIL latch_gap_p0_p1 got %0d want 259", l1 - l0); end
    n_cmp++;
    if (olow != 512) begin n_bad++; $display("FAIL plane7_oe_low got %0d want 512", olow); end
  endtask

  task automatic test_msb_plane();
    int errs, hits, hit_plane;
    errs = 0; hits = 0; hit_plane = -1;
    for (int i = 0; i < COLS*ROWS; i++) mem[i] = 24'h0;
    mem[0] = 24'h800000;
    apply_reset(2);
    release_reset();
    for (int i = 0; i < 3000 && m_nlat < 8 && errs < 10; i++) begin
      @(negedge clk_in);
      model_cycle();
      n_cmp++;
      if (!cycle_matches()) begin n_bad++; errs++; report_cycle("msb_cycle"); end
      if (bclk_out === 1'b1 && rgb_top_out[2] === 1'b1) begin hits++; hit_plane = m_plane; end
    end
    n_cmp++;
    if (hits != 1) begin n_bad++; $display("FAIL msb_r1_count got %0d want 1", hits); end
    n_cmp++;
    if (hit_plane != 7) begin n_bad++; $display("FAIL msb_r1_plane got %0d want 7", hit_plane); end
  endtask

  task automatic test_full_frame();
    int errs, nfs, nlat, nwrap;
    logic [AW-1:0] prev_row;
    errs = 0; nfs = 0; nlat = 0; nwrap = 0;
    for (int i = 0; i < COLS*ROWS; i++) mem[i] = 24'($urandom);
    apply_reset(2);
    release_reset();
    prev_row = '0;
    for (int i = 0; i < 40000 && m_nlat < HALF*BITS + 1 && errs < 10; i++) begin
      @(negedge clk_in);
      model_cycle();
      n_cmp++;
      if (!cycle_matches()) begin n_bad++; errs++; report_cycle("frame_cycle"); end
      if (frame_start_out === 1'b1) nfs++;
      if (lat_out === 1'b1) nlat++;
      if (prev_row == AW'(HALF - 1) && row_addr_out === '0) nwrap++;
      prev_row = row_addr_out;
    end
    n_cmp++;
    if (nlat != HALF*BITS + 1) begin n_bad++; $display("FAIL frame_latch_count got %0d want %0d", nlat, HALF*BITS + 1); end
    n_cmp++;
    if (nfs != 2) begin n_bad++; $display("FAIL frame_start_count got %0d want 2", nfs); end
    n_cmp++;
    if (nwrap != 1) begin n_bad++; $display("FAIL row_wrap_count got %0d want 1", nwrap); end
  endtask

  task automatic test_reset_mid_shift();
    int errs;
    bit hit;
    logic [31:0] want;
    errs = 0; hit = 0;
    want = {1'b0, 1'b0, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0};
    apply_reset(2);
    release_reset();
    for (int i = 0; i < 14000 && !hit && errs < 10; i++) begin
      @(negedge clk_in);
      model_cycle();
      n_cmp++;
      if (!cycle_matches()) begin n_bad++; errs++; report_cycle("to_row5_cycle"); end
      if (e_shift && m_row == 5 && m_plane == 0 && e_col == 30 && e_ph == 1) hit = 1;
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL reach_row5_col30 got not reached want reached"); end
    n_reset_in = 1'b0;
    @(negedge clk_in);
    n_cmp++;
    if (out_vec() !== want) begin n_bad++; $display("FAIL mid_reset_values got %h want %h", out_vec(), want); end
    release_reset();
    @(negedge clk_in);
    model_cycle();
    n_cmp++;
    if (ram_en_out !== 1'b1 || ram_addr_out !== 16'd0) begin
      n_bad++;
      $display("FAIL restart_addr got en=%b addr=%0d want en=1 addr=0", ram_en_out, ram_addr_out);
    end
    for (int i = 0; i < 600 && m_nlat < 2 && errs < 10; i++) begin
      @(negedge clk_in);
      model_cycle();
      n_cmp++;
      if (!cycle_matches()) begin n_bad++; errs++; report_cycle("after_reset_cycle"); end
    end
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    int errs, hi, lo;
    errs = 0; hi = 0; lo = 0;
    for (int i = 0; i < COLS*ROWS; i++) mem[i] = 24'($urandom);
    apply_reset(2);
    pattern_sel_in = 1'b1;
    m_pat = 1'b1;
    release_reset();
    for (int i = 0; i < 3000 && m_nlat < 8 && errs < 10; i++) begin
      @(negedge clk_in);
      model_cycle();
      n_cmp++;
      if (!cycle_matches()) begin n_bad++; errs++; report_cycle("pattern_cycle"); end
      if (e_bclk && m_plane == 7) begin
        if (e_col >= 32 && rgb_top_out === 3'b111) hi++;
        if (e_col < 32 && rgb_top_out === 3'b000) lo++;
      end
    end
    n_cmp++;
    if (hi != 32 || lo != 32) begin n_bad++; $display("FAIL pattern_plane7 got hi=%0d lo=%0d want 32/32", hi, lo); end
    pattern_sel_in = 1'b0;
    m_pat = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_first_plane();
    test_msb_plane();
    test_full_frame();
    test_reset_mid_shift();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
